// File: rtl/div_pkg.sv
// Shared constants for the divider requester: result error codes, FSM encoding
// and the rule relating the ISSUE timeout to the divider's iteration count.
package div_pkg;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // A healthy divider answers 4*WIDTH+2 cycles after enable; the timeout must exceed that.
  function automatic bit timeout_ok(input int width, input int timeout);
    return timeout > 4 * width + 2;
  endfunction

endpackage

// File: rtl/div_requester_if.sv
// Bundles the operand, divider and result channels of the requester.
// master = requester side, slave = environment (source, divider, sink).
interface div_requester_if #(
  parameter int WIDTH = 12
) ();

  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_dividend;
  logic [WIDTH-1:0] op_divisor;

  logic             div_en;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic [WIDTH-1:0] div_res;
  logic             div_busy;
  logic             div_ready;
  logic             div_take;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_quot;
  logic [1:0]       res_err;

  modport master (
    input  op_valid, op_dividend, op_divisor,
    input  div_res, div_busy, div_ready,
    input  res_ready,
    output op_ready,
    output div_en, div_dividend, div_divisor, div_take,
    output res_valid, res_quot, res_err
  );

  modport slave (
    output op_valid, op_dividend, op_divisor,
    output div_res, div_busy, div_ready,
    output res_ready,
    input  op_ready,
    input  div_en, div_dividend, div_divisor, div_take,
    input  res_valid, res_quot, res_err
  );

endinterface

// File: rtl/res_fifo.sv
// Two-entry first-word-fall-through FIFO; a push is written on the clock edge and
// is visible at the head the next cycle. Push with simultaneous pop is legal when full.
module res_fifo #(
  parameter int DW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  output logic          vld_o,
  output logic [DW-1:0] dat_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] mem0_q, mem1_q;
  logic          wr_q, rd_q;
  logic [1:0]    cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_q <= '0;
      mem1_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push && !wr_q) mem0_q <= push_dat_i;
      if (do_push && wr_q)  mem1_q <= push_dat_i;
      if (do_push)          wr_q   <= ~wr_q;
      if (do_pop)           rd_q   <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign dat_o   = rd_q ? mem1_q : mem0_q;
  assign vld_o   = (cnt_q != 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/div_requester.sv
// Issues one division at a time to an iterative divider and queues quotients with an error tag.
// op_ready only in IDLE with FIFO space, so result pushes never overflow.
module div_requester
  import div_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  div_requester_if.master bus
);

  // An undersized timeout is raised to the smallest value a healthy divider can meet.
  localparam int TO = timeout_ok(WIDTH, TIMEOUT) ? TIMEOUT : 4 * WIDTH + 3;
  localparam int CW = $clog2(TO + 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  logic             op_ready_c;
  logic             accept;
  logic             push;
  logic [WIDTH+1:0] push_dat;
  logic [WIDTH+1:0] head_dat;
  logic [1:0]       fifo_count;

  assign op_ready_c = (state_q == ST_IDLE) && (fifo_count < 2'd2) && !rst;
  assign accept     = bus.op_valid && op_ready_c;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    push     = 1'b0;
    push_dat = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (bus.op_divisor == '0) begin
            push     = 1'b1;
            push_dat = {{WIDTH{1'b0}}, ERR_DIV0};
          end else begin
            dvd_d   = bus.op_dividend;
            dvs_d   = bus.op_divisor;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        // cnt_q == 0 is the guard cycle: div_ready may still belong to the previous job.
        if ((cnt_q != '0) && bus.div_ready) begin
          state_d = ST_CAPTURE;
        end else if (cnt_q == CW'(TO - 1)) begin
          state_d  = ST_RELEASE;
          push     = 1'b1;
          push_dat = {{WIDTH{1'b0}}, ERR_TIMEOUT};
        end
      end
      ST_CAPTURE: begin
        push     = 1'b1;
        push_dat = {bus.div_res, ERR_OK};
        state_d  = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
    end
  end

  res_fifo #(.DW(WIDTH + 2)) u_res_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (bus.res_ready),
    .vld_o      (bus.res_valid),
    .dat_o      (head_dat),
    .count_o    (fifo_count)
  );

  assign bus.op_ready     = op_ready_c;
  assign bus.div_en       = (state_q == ST_ISSUE);
  assign bus.div_take     = (state_q == ST_CAPTURE);
  assign bus.div_dividend = dvd_q;
  assign bus.div_divisor  = dvs_q;
  assign bus.res_quot     = head_dat[WIDTH+1:2];
  assign bus.res_err      = head_dat[1:0];

endmodule

// File: tb/tb_div_requester.sv
// Directed bench for div_requester with a behavioural restoring divider and stuck-ready stubs.
module tb_div_requester;

  localparam int W  = 12;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_requester_if #(.WIDTH(W)) bus ();

  div_requester #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Divider: mode 0 = behavioural divider, 1 = ready stuck low, 2 = ready stuck high (result 77)
  int mode    = 0;
  int dcnt    = 0;
  bit waiting = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      bus.div_ready <= 1'b0;
      bus.div_busy  <= 1'b0;
      bus.div_res   <= '0;
      dcnt          <= 0;
      waiting       <= 1'b0;
    end else if (mode == 1) begin
      bus.div_ready <= 1'b0;
      bus.div_busy  <= 1'b0;
      bus.div_res   <= '0;
      dcnt          <= 0;
      waiting       <= 1'b0;
    end else if (mode == 2) begin
      bus.div_ready <= 1'b1;
      bus.div_busy  <= 1'b0;
      bus.div_res   <= 12'd77;
      dcnt          <= 0;
      waiting       <= 1'b0;
    end else if (!bus.div_en) begin
      dcnt     <= 0;
      waiting  <= 1'b0;
      bus.div_busy <= 1'b0;
    end else if (!waiting) begin
      if (dcnt == 0) begin
        bus.div_ready <= 1'b0;
        bus.div_busy  <= 1'b1;
      end
      if (dcnt == 4 * W + 1) begin
        bus.div_ready <= 1'b1;
        bus.div_busy  <= 1'b0;
        bus.div_res   <= bus.div_dividend / bus.div_divisor;
        waiting       <= 1'b1;
      end
      dcnt <= dcnt + 1;
    end
  end

  // Observation 1 ns after the falling edge, i.e. after that edge's stimulus has settled.
  logic [W-1:0] rq[$];
  logic [1:0]   eq[$];
  int take_cnt = 0, en_cycles = 0, low_run = 0, last_gap = -1;
  bit en_prev = 1'b0, had_en = 1'b0;

  always @(negedge clk) begin
    #1;
    if (bus.res_valid && bus.res_ready) begin
      rq.push_back(bus.res_quot);
      eq.push_back(bus.res_err);
    end
    if (bus.div_take) take_cnt++;
    if (bus.div_en) begin
      en_cycles++;
      if (!en_prev && had_en) last_gap = low_run;
      had_en  = 1'b1;
      low_run = 0;
    end else begin
      low_run++;
    end
    en_prev = bus.div_en;
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    int k;
    ok = 1'b0;
    k  = 0;
    bus.op_dividend = a;
    bus.op_divisor  = b;
    bus.op_valid    = 1'b1;
    while (!ok && k < 400) begin
      if (bus.op_ready) ok = 1'b1;
      @(negedge clk);
      k++;
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int k;
    k = 0;
    while (rq.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_chk++; if (bus.op_ready !== 1'b0) $display("FAIL rst_op_ready: got %b want 0", bus.op_ready); else n_pass++;
    n_chk++; if (bus.div_en !== 1'b0) $display("FAIL rst_div_en: got %b want 0", bus.div_en); else n_pass++;
    n_chk++; if (bus.res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.op_ready !== 1'b1) $display("FAIL post_rst_op_ready: got %b want 1", bus.op_ready); else n_pass++;
    n_chk++; if (bus.div_take !== 1'b0) $display("FAIL rst_div_take: got %b want 0", bus.div_take); else n_pass++;
    n_chk++; if ({bus.div_dividend, bus.div_divisor} !== 24'd0)
      $display("FAIL rst_operands: got %0d/%0d want 0/0", bus.div_dividend, bus.div_divisor); else n_pass++;
    n_chk++; if ({bus.res_quot, bus.res_err} !== 14'd0)
      $display("FAIL rst_head: got quot %0d err %b want 0 00", bus.res_quot, bus.res_err); else n_pass++;
  endtask

  task automatic test_basic;
    bit ok;
    int n, t0;
    bit busy_seen;
    rq.delete(); eq.delete();
    t0 = take_cnt;
    send(12'd100, 12'd7, ok);
    n_chk++; if (!ok) $display("FAIL basic_accept: op_ready never seen"); else n_pass++;
    n_chk++; if ({bus.div_en, bus.op_ready} !== 2'b10)
      $display("FAIL basic_issue: got en %b op_ready %b want 1 0", bus.div_en, bus.op_ready); else n_pass++;
    n_chk++; if ({bus.div_dividend, bus.div_divisor} !== {12'd100, 12'd7})
      $display("FAIL basic_operands: got %0d/%0d want 100/7", bus.div_dividend, bus.div_divisor); else n_pass++;
    n = 0;
    busy_seen = 1'b0;
    while (!bus.div_ready && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 10) busy_seen = bus.div_busy;
    end
    n_chk++; if (n != 4 * W + 2) $display("FAIL basic_ready_latency: got %0d want %0d", n, 4 * W + 2); else n_pass++;
    n_chk++; if (!busy_seen) $display("FAIL basic_busy: got 0 want 1 mid-division"); else n_pass++;
    @(negedge clk);
    n_chk++; if ({bus.div_take, bus.div_en, bus.res_valid} !== 3'b100)
      $display("FAIL basic_capture: got take/en/valid %b%b%b want 100", bus.div_take, bus.div_en, bus.res_valid); else n_pass++;
    @(negedge clk);
    n_chk++; if ({bus.res_valid, bus.res_quot, bus.res_err} !== {1'b1, 12'd14, 2'b00})
      $display("FAIL basic_result: got v %b q %0d e %b want 1 14 00", bus.res_valid, bus.res_quot, bus.res_err); else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++; if (take_cnt - t0 != 1) $display("FAIL basic_take_pulses: got %0d want 1", take_cnt - t0); else n_pass++;
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2;
    logic [W-1:0] q0, q1;
    rq.delete(); eq.delete();
    last_gap = -1;
    send(12'd4095, 12'd1, ok1);
    send(12'd12, 12'd4095, ok2);
    @(negedge clk);
    n_chk++; if (!(ok1 && ok2)) $display("FAIL b2b_accept: got ok %b%b want 11", ok1, ok2); else n_pass++;
    // Between jobs en is low for CAPTURE, RELEASE and the IDLE acceptance cycle.
    n_chk++; if (last_gap != 3) $display("FAIL b2b_en_gap: got %0d want 3", last_gap); else n_pass++;
    wait_q(2);
    q0 = (rq.size() > 0) ? rq[0] : 'x;
    q1 = (rq.size() > 1) ? rq[1] : 'x;
    n_chk++; if (rq.size() != 2) $display("FAIL b2b_count: got %0d want 2", rq.size()); else n_pass++;
    n_chk++; if ({q0, q1} !== {12'd4095, 12'd0}) $display("FAIL b2b_order: got %0d,%0d want 4095,0", q0, q1); else n_pass++;
  endtask

  task automatic test_div0;
    bit ok1, ok2;
    int e0;
    rq.delete(); eq.delete();
    e0 = en_cycles;
    send(12'd55, 12'd0, ok1);
    n_chk++; if ({bus.res_valid, bus.res_quot, bus.res_err} !== {1'b1, 12'd0, 2'b01})
      $display("FAIL div0_result: got v %b q %0d e %b want 1 0 01", bus.res_valid, bus.res_quot, bus.res_err); else n_pass++;
    send(12'd3, 12'd0, ok2);
    n_chk++; if (!(ok1 && ok2)) $display("FAIL div0_b2b_accept: got ok %b%b want 11", ok1, ok2); else n_pass++;
    n_chk++; if ({bus.res_valid, bus.res_err} !== 3'b101)
      $display("FAIL div0_second: got v %b e %b want 1 01", bus.res_valid, bus.res_err); else n_pass++;
    repeat (4) @(negedge clk);
    n_chk++; if (rq.size() != 2) $display("FAIL div0_count: got %0d want 2", rq.size()); else n_pass++;
    n_chk++; if (en_cycles != e0) $display("FAIL div0_no_en: got %0d en cycles want 0", en_cycles - e0); else n_pass++;
  endtask

  task automatic test_backpressure;
    bit ok1, ok2, ok3;
    logic [W-1:0] q0, q1, q2;
    rq.delete(); eq.delete();
    bus.res_ready = 1'b0;
    send(12'd8, 12'd2, ok1);
    send(12'd9, 12'd3, ok2);
    bus.op_dividend = 12'd10;
    bus.op_divisor  = 12'd5;
    bus.op_valid    = 1'b1;
    repeat (70) @(negedge clk);
    n_chk++; if ({bus.op_ready, bus.div_en} !== 2'b00)
      $display("FAIL bp_full_stall: got op_ready %b en %b want 0 0", bus.op_ready, bus.div_en); else n_pass++;
    n_chk++; if ({bus.res_valid, bus.res_quot} !== {1'b1, 12'd4})
      $display("FAIL bp_head_first: got v %b q %0d want 1 4", bus.res_valid, bus.res_quot); else n_pass++;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    send(12'd10, 12'd5, ok3);
    n_chk++; if (!(ok1 && ok2 && ok3)) $display("FAIL bp_accept: got ok %b%b%b want 111", ok1, ok2, ok3); else n_pass++;
    repeat (70) @(negedge clk);
    n_chk++; if ({bus.res_valid, bus.res_quot, bus.op_ready} !== {1'b1, 12'd3, 1'b0})
      $display("FAIL bp_head_stable: got v %b q %0d op_ready %b want 1 3 0", bus.res_valid, bus.res_quot, bus.op_ready); else n_pass++;
    bus.res_ready = 1'b1;
    wait_q(3);
    q0 = (rq.size() > 0) ? rq[0] : 'x;
    q1 = (rq.size() > 1) ? rq[1] : 'x;
    q2 = (rq.size() > 2) ? rq[2] : 'x;
    n_chk++; if ({q0, q1, q2} !== {12'd4, 12'd3, 12'd2})
      $display("FAIL bp_results: got %0d,%0d,%0d want 4,3,2", q0, q1, q2); else n_pass++;
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    mode = 1;
    rq.delete(); eq.delete();
    @(negedge clk);
    send(12'd1, 12'd1, ok);
    n = 0;
    while (bus.div_en && n < 200) begin
      n++;
      @(negedge clk);
    end
    n_chk++; if (n != TO) $display("FAIL timeout_issue_len: got %0d want %0d", n, TO); else n_pass++;
    n_chk++; if ({bus.res_valid, bus.res_quot, bus.res_err} !== {1'b1, 12'd0, 2'b10})
      $display("FAIL timeout_result: got v %b q %0d e %b want 1 0 10", bus.res_valid, bus.res_quot, bus.res_err); else n_pass++;
    @(negedge clk);
    n_chk++; if (bus.div_en !== 1'b0) $display("FAIL timeout_release: got en %b want 0", bus.div_en); else n_pass++;
  endtask

  task automatic test_stuck_ready;
    bit ok;
    int n;
    mode = 2;
    rq.delete(); eq.delete();
    repeat (3) @(negedge clk);
    send(12'd5, 12'd5, ok);
    n = 0;
    while (bus.div_en && n < 200) begin
      n++;
      @(negedge clk);
    end
    n_chk++; if (n != 2) $display("FAIL guard_issue_len: got %0d want 2", n); else n_pass++;
    n_chk++; if (bus.div_take !== 1'b1) $display("FAIL guard_take: got %b want 1", bus.div_take); else n_pass++;
    @(negedge clk);
    n_chk++; if ({bus.res_valid, bus.res_quot, bus.res_err} !== {1'b1, 12'd77, 2'b00})
      $display("FAIL guard_result: got v %b q %0d e %b want 1 77 00", bus.res_valid, bus.res_quot, bus.res_err); else n_pass++;
    repeat (3) @(negedge clk);
    mode = 0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int t0, s0;
    logic [W-1:0] q;
    rq.delete(); eq.delete();
    send(12'd200, 12'd3, ok);
    repeat (20) @(negedge clk);
    t0 = take_cnt;
    s0 = rq.size();
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if ({bus.div_en, bus.div_take, bus.res_valid, bus.op_ready} !== 4'b0000)
      $display("FAIL midrst_ctrl: got en/take/valid/op_ready %b%b%b%b want 0000",
               bus.div_en, bus.div_take, bus.res_valid, bus.op_ready); else n_pass++;
    n_chk++; if ({bus.div_dividend, bus.div_divisor, bus.res_quot, bus.res_err} !== 38'd0)
      $display("FAIL midrst_data: got %0d/%0d head %0d %b want all 0",
               bus.div_dividend, bus.div_divisor, bus.res_quot, bus.res_err); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.op_ready !== 1'b1) $display("FAIL midrst_op_ready: got %b want 1", bus.op_ready); else n_pass++;
    repeat (60) @(negedge clk);
    n_chk++; if ((rq.size() != s0) || (take_cnt != t0))
      $display("FAIL midrst_discard: got %0d results %0d takes want 0 0", rq.size() - s0, take_cnt - t0); else n_pass++;
    send(12'd30, 12'd6, ok);
    wait_q(s0 + 1);
    q = (rq.size() > s0) ? rq[s0] : 'x;
    n_chk++; if (q !== 12'd5) $display("FAIL midrst_next_job: got %0d want 5", q); else n_pass++;
  endtask

  initial begin
    bus.op_valid    = 1'b0;
    bus.op_dividend = '0;
    bus.op_divisor  = '0;
    bus.res_ready   = 1'b1;
    test_reset;
    test_basic;
    test_back_to_back;
    test_div0;
    test_backpressure;
    test_timeout;
    test_stuck_ready;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
